// File: rtl/taxi_fare_meter.sv
// Taxi fare engine: trip FSM, distance/waiting counters, four-band tariff with
// per-trip night surcharge and saturating fare accumulation.
module taxi_fare_meter #(
  parameter int unsigned FARE_W          = 12,
  parameter int unsigned VEL_W           = 8,
  parameter int unsigned BASE_FARE       = 300,
  parameter int unsigned V1              = 30,
  parameter int unsigned V2              = 50,
  parameter int unsigned V3              = 70,
  parameter int unsigned INC0            = 10,
  parameter int unsigned INC1            = 12,
  parameter int unsigned INC2            = 14,
  parameter int unsigned INC3            = 16,
  parameter int unsigned PULSES_PER_UNIT = 4,
  parameter int unsigned WAIT_CYCLES     = 1000,
  parameter int unsigned WAIT_INC        = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic              Stop,
  input  logic              Pause,
  input  logic              Night,
  input  logic [VEL_W-1:0]  Velocity,
  input  logic              dist_pulse,
  output logic [FARE_W-1:0] out,
  output logic [1:0]        state,
  output logic              sat
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StPaused = 2'b10,
    StDone   = 2'b11
  } state_e;

  localparam int unsigned SumW  = FARE_W + 2;
  localparam int unsigned DistW = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
  localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [SumW-1:0] FareMax = {2'b00, {FARE_W{1'b1}}};

  function automatic logic [SumW-1:0] scale_inc(input logic [SumW-1:0] inc, input logic nt);
    return nt ? inc + (inc >> 1) : inc;
  endfunction

  state_e            state_q, state_d;
  logic [FARE_W-1:0] fare_q, fare_d;
  logic              sat_q, sat_d;
  logic              night_q, night_d;
  logic [DistW-1:0]  dist_cnt_q, dist_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;

  logic [SumW-1:0] band_inc;
  logic [SumW-1:0] start_fare;
  logic [SumW-1:0] dist_add;
  logic [SumW-1:0] wait_add;
  logic [SumW-1:0] acc_sum;
  logic            dist_hit;
  logic            wait_hit;
  logic            stationary;

  always_comb begin
    if (Velocity < VEL_W'(V1)) begin
      band_inc = SumW'(INC0);
    end else if (Velocity < VEL_W'(V2)) begin
      band_inc = SumW'(INC1);
    end else if (Velocity < VEL_W'(V3)) begin
      band_inc = SumW'(INC2);
    end else begin
      band_inc = SumW'(INC3);
    end
  end

  assign stationary = (Velocity == '0);
  assign dist_hit   = dist_pulse && (dist_cnt_q == DistW'(PULSES_PER_UNIT - 1));
  assign wait_hit   = stationary && (wait_cnt_q == WaitW'(WAIT_CYCLES - 1));
  assign start_fare = scale_inc(SumW'(BASE_FARE), Night);
  assign dist_add   = dist_hit ? scale_inc(band_inc, night_q) : '0;
  assign wait_add   = wait_hit ? scale_inc(SumW'(WAIT_INC), night_q) : '0;
  // Both charges are summed before the single saturation check.
  assign acc_sum    = {2'b00, fare_q} + dist_add + wait_add;

  always_comb begin
    state_d    = state_q;
    fare_d     = fare_q;
    sat_d      = sat_q;
    night_d    = night_q;
    dist_cnt_d = dist_cnt_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d    = StRun;
          night_d    = Night;
          dist_cnt_d = '0;
          wait_cnt_d = '0;
          if (start_fare > FareMax) begin
            fare_d = FareMax[FARE_W-1:0];
            sat_d  = 1'b1;
          end else begin
            fare_d = start_fare[FARE_W-1:0];
            sat_d  = 1'b0;
          end
        end
      end

      StRun: begin
        if (Stop) begin
          state_d    = StDone;
          wait_cnt_d = '0;
        end else if (Pause) begin
          state_d    = StPaused;
          wait_cnt_d = '0;
        end else begin
          if (dist_pulse) begin
            dist_cnt_d = dist_hit ? '0 : dist_cnt_q + DistW'(1);
          end
          if (!stationary || wait_hit) begin
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
          if (acc_sum > FareMax) begin
            fare_d = FareMax[FARE_W-1:0];
            sat_d  = 1'b1;
          end else begin
            fare_d = acc_sum[FARE_W-1:0];
          end
        end
      end

      StPaused: begin
        if (Stop) begin
          state_d = StDone;
        end else if (!Pause) begin
          state_d = StRun;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      fare_q     <= '0;
      sat_q      <= 1'b0;
      night_q    <= 1'b0;
      dist_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fare_q     <= fare_d;
      sat_q      <= sat_d;
      night_q    <= night_d;
      dist_cnt_q <= dist_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign out   = fare_q;
  assign state = state_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_taxi_fare_meter.sv
// Bench for taxi_fare_meter: a default instance and a narrow 9-bit instance share
// stimulus; both are compared every cycle against a trip-level fare model.
module tb_taxi_fare_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, pause, night, pulse;
  logic [7:0] vel;

  logic [11:0] out_a;
  logic [1:0]  state_a;
  logic        sat_a;
  logic [8:0]  out_b;
  logic [1:0]  state_b;
  logic        sat_b;

  taxi_fare_meter u_dut_a (
    .CLK        (clk),
    .RST        (rst),
    .Start      (start),
    .Stop       (stop),
    .Pause      (pause),
    .Night      (night),
    .Velocity   (vel),
    .dist_pulse (pulse),
    .out        (out_a),
    .state      (state_a),
    .sat        (sat_a)
  );

  taxi_fare_meter #(
    .FARE_W          (9),
    .PULSES_PER_UNIT (3),
    .WAIT_CYCLES     (20)
  ) u_dut_b (
    .CLK        (clk),
    .RST        (rst),
    .Start      (start),
    .Stop       (stop),
    .Pause      (pause),
    .Night      (night),
    .Velocity   (vel),
    .dist_pulse (pulse),
    .out        (out_b),
    .state      (state_b),
    .sat        (sat_b)
  );

  typedef struct {
    int unsigned fw;
    int unsigned ppu;
    int unsigned wc;
    int unsigned mode;
    int unsigned fare;
    int unsigned dcnt;
    int unsigned wcnt;
    bit          sat;
    bit          nt;
  } model_t;

  model_t      m_a, m_b;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned eff(input int unsigned inc, input bit nt);
    return nt ? inc + inc / 2 : inc;
  endfunction

  function automatic int unsigned band(input int unsigned v);
    if (v < 30) return 10;
    if (v < 50) return 12;
    if (v < 70) return 14;
    return 16;
  endfunction

  // Trip-level reference: one clock of the meter expressed in plain arithmetic.
  function automatic model_t step(input model_t s);
    int unsigned top;
    int unsigned add;
    int unsigned base;
    top = (1 << s.fw) - 1;
    add = 0;
    if (rst) begin
      s.mode = 0; s.fare = 0; s.sat = 0; s.dcnt = 0; s.wcnt = 0; s.nt = 0;
      return s;
    end
    case (s.mode)
      0, 3: if (start) begin
        s.mode = 1;
        s.nt   = night;
        base   = eff(300, night);
        s.sat  = base > top;
        s.fare = s.sat ? top : base;
        s.dcnt = 0;
        s.wcnt = 0;
      end
      1: begin
        if (stop) begin
          s.mode = 3; s.wcnt = 0;
        end else if (pause) begin
          s.mode = 2; s.wcnt = 0;
        end else begin
          if (pulse) begin
            s.dcnt++;
            if (s.dcnt == s.ppu) begin
              s.dcnt = 0;
              add += eff(band(int'(vel)), s.nt);
            end
          end
          if (vel == 0) begin
            s.wcnt++;
            if (s.wcnt == s.wc) begin
              s.wcnt = 0;
              add += eff(5, s.nt);
            end
          end else begin
            s.wcnt = 0;
          end
          if (s.fare + add > top) begin
            s.fare = top; s.sat = 1;
          end else begin
            s.fare += add;
          end
        end
      end
      default: begin
        if (stop) s.mode = 3;
        else if (!pause) s.mode = 1;
      end
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_a = step(m_a);
    m_b = step(m_b);
    @(negedge clk);
    check_eq("a_state", state_a, m_a.mode);
    check_eq("a_out", out_a, m_a.fare);
    check_eq("a_sat", sat_a, m_a.sat);
    check_eq("b_state", state_b, m_b.mode);
    check_eq("b_out", out_b, m_b.fare);
    check_eq("b_sat", sat_b, m_b.sat);
  endtask

  task automatic one_pulse();
    pulse = 1'b1;
    tick();
    pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_a = '{fw: 12, ppu: 4, wc: 1000, default: 0};
    m_b = '{fw: 9, ppu: 3, wc: 20, default: 0};
    rst = 1'b1; start = 0; stop = 0; pause = 0; night = 0; pulse = 0; vel = 8'd40;

    // Reset state
    tick();
    rst = 1'b0;
    check_eq("rst_state", state_a, 0);
    check_eq("rst_out", out_a, 0);
    check_eq("rst_sat", sat_a, 0);

    // Day trip start, then one charged unit at band1
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_state", state_a, 1);
    check_eq("start_out", out_a, 300);
    for (int i = 0; i < 4; i++) begin
      one_pulse();
      check_eq(i < 3 ? "pulse_hold" : "pulse_unit", out_a, i < 3 ? 300 : 312);
    end
    one_pulse();
    check_eq("pulse_wrap", out_a, 312);

    // Night trip, band3 unit, then one waiting charge
    do_reset();
    night = 1'b1; vel = 8'd80; start = 1'b1;
    tick();
    start = 1'b0; night = 1'b0;
    check_eq("night_base", out_a, 450);
    for (int i = 0; i < 4; i++) one_pulse();
    check_eq("night_unit", out_a, 474);
    vel = 8'd0;
    repeat (999) tick();
    check_eq("wait_hold", out_a, 474);
    tick();
    check_eq("wait_charge", out_a, 481);

    // Pause freezes the distance counter
    do_reset();
    vel = 8'd40; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) one_pulse();
    pause = 1'b1;
    tick();
    check_eq("pause_state", state_a, 2);
    repeat (5) one_pulse();
    check_eq("pause_out", out_a, 300);
    pause = 1'b0;
    tick();
    check_eq("resume_state", state_a, 1);
    repeat (2) one_pulse();
    check_eq("resume_out", out_a, 312);
    pause = 1'b1; stop = 1'b1;
    tick();
    check_eq("stop_pri_state", state_a, 3);
    check_eq("stop_pri_out", out_a, 312);
    pause = 1'b0;
    one_pulse();
    check_eq("done_hold", out_a, 312);
    stop = 1'b0;

    // Saturation on the 9-bit instance
    do_reset();
    vel = 8'd80; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (39) one_pulse();
    check_eq("sat_near", out_b, 508);
    check_eq("sat_near_flag", sat_b, 0);
    repeat (3) one_pulse();
    check_eq("sat_out", out_b, 511);
    check_eq("sat_flag", sat_b, 1);
    repeat (3) one_pulse();
    check_eq("sat_keep", out_b, 511);
    stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("restart_out", out_b, 300);
    check_eq("restart_sat", sat_b, 0);

    // Reset mid-trip wins over a simultaneous Start
    vel = 8'd40;
    repeat (16) one_pulse();
    check_eq("mid_out", out_a, 348);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_eq("abort_state", state_a, 0);
    check_eq("abort_out", out_a, 0);
    tick();
    check_eq("abort_idle", state_a, 0);

    // Randomized trips with held velocity streaks
    begin
      int unsigned streak;
      streak = 0;
      for (int i = 0; i < 4000; i++) begin
        if (streak == 0) begin
          streak = $urandom_range(40, 1);
          vel = ($urandom_range(9, 0) < 3) ? 8'd0 : 8'($urandom_range(255, 1));
        end
        streak--;
        rst   = ($urandom_range(999, 0) < 4);
        start = ($urandom_range(99, 0) < 5);
        stop  = ($urandom_range(99, 0) < 2);
        pause = ($urandom_range(99, 0) < 8);
        night = $urandom_range(1, 0) != 0;
        pulse = ($urandom_range(9, 0) < 4);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
